// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Single-port memory arbiter between the 6502 core and a debug/loader port.
//   Every access runs IDLE -> ACCESS -> RESP -> IDLE, and ACCESS lasts
//   WAIT_STATES+1 cycles. The CPU has priority. After CPU_BURST_MAX CPU grants
//   in a row while dbg_req is pending, the next grant goes to the debug port.
//
// Optional feature macro: MEM_ARB_ROM_PROTECT_EN
//   A CPU write at or above ROM_BASE is sequenced normally but never strobes
//   mem_we, and it sets the sticky rom_wr_err flag. Debug writes always
//   reach memory.
//
// Ports
//   ph1, reset           clock; synchronous active-low reset
//   cpu_*                CPU request/we/addr/wdata in; rdata/ack out
//   dbg_*                debug request/we/addr/wdata in; rdata/ack out
//   mem_en/we/addr/wdata registered memory controls; mem_rdata in
//   owner                last-granted requester (0 = CPU, 1 = debug)
//   rom_wr_err           sticky blocked-ROM-write flag (feature builds only)

module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES   = 1,
    parameter int unsigned CPU_BURST_MAX = 8,
    parameter logic [15:0] ROM_BASE      = 16'hF000
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic [7:0]  dbg_rdata,
    output logic        dbg_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        owner
`ifdef MEM_ARB_ROM_PROTECT_EN
   ,output logic        rom_wr_err
`endif
);

    localparam logic [3:0] WS        = 4'(WAIT_STATES);
    localparam logic [7:0] BURST_MAX = 8'(CPU_BURST_MAX);
`ifdef MEM_ARB_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  wcnt;
    logic [7:0]  burst_cnt;
    logic        lat_we;     // latched direction; kept separate from mem_we so a
                             // blocked ROM write still skips the rdata capture

    logic        dbg_win;
    logic        sel_we;
    logic        rom_block;

    // Debug wins when it is the only requester, or when the CPU burst limit has been reached.
    assign dbg_win   = dbg_req && (!cpu_req || burst_cnt == BURST_MAX);
    assign sel_we    = dbg_win ? dbg_we : cpu_we;
    assign rom_block = ROM_PROTECT && !dbg_win && cpu_we && (cpu_addr >= ROM_BASE);

    always_ff @(posedge ph1) begin
        if (!reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            burst_cnt <= '0;
            lat_we    <= 1'b0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
`ifdef MEM_ARB_ROM_PROTECT_EN
            rom_wr_err <= 1'b0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner     <= dbg_win;
                        mem_addr  <= dbg_win ? dbg_addr  : cpu_addr;
                        mem_wdata <= dbg_win ? dbg_wdata : cpu_wdata;
                        lat_we    <= sel_we;
                        mem_we    <= sel_we && !rom_block;
                        mem_en    <= 1'b1;
                        wcnt      <= WS;
                        state     <= ACCESS;
                        // Count only the CPU grants that keep a waiting debug request waiting.
                        if (dbg_win || !dbg_req)
                            burst_cnt <= '0;
                        else if (burst_cnt != BURST_MAX)
                            burst_cnt <= burst_cnt + 8'd1;
`ifdef MEM_ARB_ROM_PROTECT_EN
                        if (rom_block)
                            rom_wr_err <= 1'b1;
`endif
                    end
                end
                ACCESS: begin
                    if (wcnt == 4'd0) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= RESP;
                        if (!lat_we) begin
                            if (owner) dbg_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        // Set the ack on entry to RESP, so it is high for exactly the RESP cycle.
                        if (owner) dbg_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (default parameters: WAIT_STATES=1,
// CPU_BURST_MAX=8). The bench has its own 256-byte memory model, indexed by
// mem_addr[7:0]. The model is preloaded while reset is low.

module tb_mem_bus_arbiter;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, dbg_addr;
    logic [7:0]  cpu_wdata, dbg_wdata;
    logic [7:0]  cpu_rdata, dbg_rdata;
    logic        cpu_ack, dbg_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        owner;
`ifdef MEM_ARB_ROM_PROTECT_EN
    logic        rom_wr_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 ph1 = ~ph1;

    mem_bus_arbiter dut (
        .ph1(ph1), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
`ifdef MEM_ARB_ROM_PROTECT_EN
       ,.rom_wr_err(rom_wr_err)
`endif
    );

    // Memory model: mem[i] = i ^ 5A, except mem[30] = 9D.
    logic [7:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge ph1) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h30] <= 8'h9D;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    // Wait for the selected ack; the cycle count is bounded and reported in n.
    task automatic wait_ack(input bit dbg, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(dbg ? dbg_ack : cpu_ack) && n < 32);
    endtask

    task automatic wait_any(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(cpu_ack || dbg_ack) && n < 32);
    endtask

    // One complete transaction, started from IDLE and finished back in IDLE.
    task automatic xact(input bit dbg, input bit we, input logic [15:0] a,
                        input logic [7:0] d, output int lat, output bit saw_we);
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        lat = 0;
        saw_we = 0;
        do begin
            step();
            lat++;
            if (mem_we) saw_we = 1;
        end while (!(dbg ? dbg_ack : cpu_ack) && lat < 32);
        cpu_req = 0;
        dbg_req = 0;
        step();
    endtask

    int  n, m, any_ack;
    bit  sw;
    bit  who;

    initial begin
        reset = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

        // Reset hold with a pending CPU request
        cpu_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_mem_en_%0d", i), 32'(mem_en), 0);
        end
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_dbg_ack", 32'(dbg_ack), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        reset = 1;
        wait_ack(0, n);
        chk("rst_first_ack_lat", 32'(n), 3);
        cpu_req = 0;
        step();

        // CPU read of 0030. cpu_req is dropped mid-transaction, but the ack must still arrive.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
        step();
        chk("rd_c1_mem_en", 32'(mem_en), 1);
        chk("rd_c1_addr", 32'(mem_addr), 32'h0030);
        chk("rd_c1_ack", 32'(cpu_ack), 0);
        cpu_req = 0;
        step();
        chk("rd_c2_mem_en", 32'(mem_en), 1);
        step();
        chk("rd_c3_mem_en", 32'(mem_en), 0);
        chk("rd_c3_ack", 32'(cpu_ack), 1);
        chk("rd_c3_rdata", 32'(cpu_rdata), 32'h9D);
        step();
        chk("rd_c4_ack", 32'(cpu_ack), 0);
        chk("rd_c4_rdata_held", 32'(cpu_rdata), 32'h9D);

        // CPU write 3C -> 0040; cpu_rdata must not change
        xact(0, 1, 16'h0040, 8'h3C, n, sw);
        chk("wr_lat", 32'(n), 3);
        chk("wr_mem_we_seen", 32'(sw), 1);
        chk("wr_mem_0040", 32'(mem[8'h40]), 32'h3C);
        chk("wr_cpu_rdata_keep", 32'(cpu_rdata), 32'h9D);

        // Simultaneous requests: the CPU is served first, then debug WAIT_STATES+3 cycles later
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0040;
        step();
        chk("sim_owner_cpu", 32'(owner), 0);
        wait_ack(0, n);
        chk("sim_cpu_lat", 32'(n), 2);
        cpu_req = 0;
        wait_ack(1, m);
        chk("sim_dbg_gap", 32'(m), 4);
        chk("sim_owner_dbg", 32'(owner), 1);
        chk("sim_dbg_rdata", 32'(dbg_rdata), 32'h3C);
        chk("sim_cpu_ack_low", 32'(cpu_ack), 0);
        dbg_req = 0;
        step();

        // Starvation: both requesters stay active; debug should get every 9th grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0040;
        for (int g = 1; g <= 18; g++) begin
            wait_any(n);
            who = dbg_ack;
            chk($sformatf("starve_grant_%0d", g), 32'(who), 32'((g % 9) == 0));
            chk($sformatf("starve_gap_%0d", g), 32'(n), (g == 1) ? 32'd3 : 32'd4);
        end
        cpu_req = 0;
        dbg_req = 0;
        step();

        // Reset in the middle of a debug write: the transaction is abandoned and no ack is sent
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0030; dbg_wdata = 8'h77;
        step();
        chk("rma_mem_en", 32'(mem_en), 1);
        chk("rma_mem_we", 32'(mem_we), 1);
        chk("rma_owner", 32'(owner), 1);
        reset = 0;
        step();
        chk("rma_mem_en_off", 32'(mem_en), 0);
        chk("rma_mem_we_off", 32'(mem_we), 0);
        chk("rma_dbg_ack", 32'(dbg_ack), 0);
        chk("rma_dbg_rdata_clr", 32'(dbg_rdata), 0);
        reset = 1;
        dbg_req = 0;
        any_ack = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (dbg_ack || cpu_ack) any_ack = 1;
        end
        chk("rma_no_ack", 32'(any_ack), 0);
        xact(1, 0, 16'h0040, 8'h00, n, sw);
        chk("rma_dbg_rd_lat", 32'(n), 3);
        chk("rma_dbg_rdata", 32'(dbg_rdata), 32'h1A);

`ifdef MEM_ARB_ROM_PROTECT_EN
        chk("rom_err_init", 32'(rom_wr_err), 0);
        xact(0, 1, 16'hF010, 8'h55, n, sw);
        chk("rom_cpu_lat", 32'(n), 3);
        chk("rom_cpu_mem_we", 32'(sw), 0);
        chk("rom_err_set", 32'(rom_wr_err), 1);
        chk("rom_cpu_mem_keep", 32'(mem[8'h10]), 32'h4A);
        xact(1, 1, 16'hF010, 8'hAA, n, sw);
        chk("rom_dbg_mem_we", 32'(sw), 1);
        chk("rom_dbg_mem", 32'(mem[8'h10]), 32'hAA);
        chk("rom_err_sticky", 32'(rom_wr_err), 1);
`else
        xact(0, 1, 16'hF010, 8'h55, n, sw);
        chk("hi_cpu_lat", 32'(n), 3);
        chk("hi_cpu_mem_we", 32'(sw), 1);
        chk("hi_cpu_mem", 32'(mem[8'h10]), 32'h55);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
